python_emulator: RTL and testbench

//  Cycle-accurate emulator of one Python image-sensor LVDS port after deserialisation: drives the
//  8-bit sync channel and 4x8-bit data lanes that python_decoder consumes (cam_N_rxd[39:0]).

---
 rtl/python_emulator.sv | 208 ++++++++++++++++++++
 tb/tb_python_emulator.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/python_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : python_emulator
//  Purpose  : Cycle-accurate stand-in for one Python image-sensor LVDS port
//             after deserialisation. Emits one frame of sync + 4-lane pixel
//             words per accepted trigger, framed by FS/LS/LE/FE sync codes
//             and separated by horizontal-blanking training words.
//  Ports    : c          in   1   clock (cam rxc domain of the emulated port)
//             rst        in   1   synchronous, active-high reset
//             en         in   1   trigger enable; triggers ignored when low
//             trigger    in   1   frame request, level-sampled while idle
//             q          out  40  {sync[7:0], lane3, lane2, lane1, lane0}
//             busy       out  1   high from trigger accept through FE word
//             frame_cnt  out  16  completed frames, wraps at 16'hFFFF -> 0
//  Revision : 1.0  initial release
// ============================================================================
module python_emulator #(
    parameter int          KERNELS    = 320,
    parameter int          LINES      = 1024,
    parameter int          H_BLANK    = 16,
    parameter int          TRIG_DELAY = 8,
    parameter logic [7:0]  SYNC_FS    = 8'hAA,
    parameter logic [7:0]  SYNC_FE    = 8'hCA,
    parameter logic [7:0]  SYNC_LS    = 8'h2A,
    parameter logic [7:0]  SYNC_LE    = 8'h4A,
    parameter logic [7:0]  SYNC_IMG   = 8'h0D,
    parameter logic [7:0]  SYNC_TR    = 8'hE9
) (
    input  logic        c,
    input  logic        rst,
    input  logic        en,
    input  logic        trigger,
    output logic [39:0] q,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    // ------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------
    localparam int C_KW   = (KERNELS > 1) ? $clog2(KERNELS) : 1;
    localparam int C_LW   = (LINES > 1) ? $clog2(LINES) : 1;
    // One shared down-the-line counter serves both the trigger delay and
    // the horizontal blanking, so it must hold the larger of the two.
    localparam int C_CMAX = (TRIG_DELAY > H_BLANK) ? TRIG_DELAY : H_BLANK;
    localparam int C_CW   = (C_CMAX > 0) ? $clog2(C_CMAX + 1) : 1;

    localparam logic [C_KW-1:0] C_K_LAST = C_KW'(KERNELS - 1);
    localparam logic [C_LW-1:0] C_L_LAST = C_LW'(LINES - 1);
    localparam logic [C_CW-1:0] C_TD     = C_CW'(TRIG_DELAY);
    localparam logic [C_CW-1:0] C_HB     = C_CW'(H_BLANK);
    localparam logic [39:0]     C_TR_WORD = {SYNC_TR, 32'h0000_0000};

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_LINE   = 2'd2;
    localparam logic [1:0] ST_HBLANK = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // r_k / r_l always describe the word currently presented on q while
    // in ST_LINE; the next-word logic therefore works one step ahead.
    logic [1:0]      r_state;
    logic [C_KW-1:0] r_k;
    logic [C_LW-1:0] r_l;
    logic [C_CW-1:0] r_cnt;

    logic [1:0]      w_state_nxt;
    logic [C_KW-1:0] w_k_nxt;
    logic [C_LW-1:0] w_l_nxt;
    logic [C_CW-1:0] w_cnt_nxt;
    logic            w_busy_nxt;
    logic [15:0]     w_fc_nxt;
    logic            w_emit_tr;

    logic [7:0]      w_sync;
    logic [7:0]      w_k8;
    logic [7:0]      w_l8;
    logic [7:0]      w_base;
    logic [31:0]     w_data;
    logic [39:0]     w_q_nxt;

    // ------------------------------------------------------------------
    // Next-state / next-word sequencing
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_l_nxt     = r_l;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = busy;
        w_fc_nxt    = frame_cnt;
        w_emit_tr   = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (trigger && en) begin
                    w_busy_nxt = 1'b1;
                    if (TRIG_DELAY == 0) begin
                        w_state_nxt = ST_LINE;
                        w_k_nxt     = '0;
                        w_l_nxt     = '0;
                        w_emit_tr   = 1'b0;
                    end else begin
                        // This cycle's output is the first of the delay words.
                        w_state_nxt = ST_DELAY;
                        w_cnt_nxt   = C_CW'(1);
                    end
                end
            end

            ST_DELAY: begin
                if (r_cnt == C_TD) begin
                    w_state_nxt = ST_LINE;
                    w_k_nxt     = '0;
                    w_l_nxt     = '0;
                    w_emit_tr   = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + C_CW'(1);
                end
            end

            ST_LINE: begin
                if (r_k == C_K_LAST) begin
                    if (r_l == C_L_LAST) begin
                        // FE word is on q now: close the frame next cycle.
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_fc_nxt    = frame_cnt + 16'd1;
                    end else begin
                        w_state_nxt = ST_HBLANK;
                        w_cnt_nxt   = C_CW'(1);
                    end
                end else begin
                    w_k_nxt   = r_k + C_KW'(1);
                    w_emit_tr = 1'b0;
                end
            end

            ST_HBLANK: begin
                if (r_cnt == C_HB) begin
                    w_state_nxt = ST_LINE;
                    w_k_nxt     = '0;
                    w_l_nxt     = r_l + C_LW'(1);
                    w_emit_tr   = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + C_CW'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Word formatting for the upcoming kernel
    // ------------------------------------------------------------------
    always_comb begin
        w_sync = SYNC_IMG;
        if (w_k_nxt == '0) begin
            w_sync = (w_l_nxt == '0) ? SYNC_FS : SYNC_LS;
        end else if (w_k_nxt == C_K_LAST) begin
            w_sync = (w_l_nxt == C_L_LAST) ? SYNC_FE : SYNC_LE;
        end
    end

    // Only the low byte of each term matters: lanes are mod-256 sums.
    assign w_k8   = 8'(w_k_nxt);
    assign w_l8   = 8'(w_l_nxt);
    assign w_base = w_l8 + (w_k8 << 2) + frame_cnt[7:0];

    generate
        for (genvar j = 0; j < 4; j++) begin : g_lane
            assign w_data[8*j +: 8] = w_base + 8'(j);
        end
    endgenerate

    assign w_q_nxt = w_emit_tr ? C_TR_WORD : {w_sync, w_data};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge c) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_k       <= '0;
            r_l       <= '0;
            r_cnt     <= '0;
            q         <= C_TR_WORD;
            busy      <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_l       <= w_l_nxt;
            r_cnt     <= w_cnt_nxt;
            q         <= w_q_nxt;
            busy      <= w_busy_nxt;
            frame_cnt <= w_fc_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_python_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_python_emulator
//  Purpose  : Self-checking bench for python_emulator (small frame geometry)
//             with a queue-based frame model, directed literal checks and a
//             randomized trigger/en/rst phase.
//  Revision : 1.0  initial release
// ============================================================================
module tb_python_emulator;

    localparam int KERNELS    = 4;
    localparam int LINES      = 3;
    localparam int H_BLANK    = 2;
    localparam int TRIG_DELAY = 1;
    localparam logic [39:0] TR_WORD = 40'hE9_0000_0000;

    logic        c;
    logic        rst;
    logic        en;
    logic        trigger;
    logic [39:0] q;
    logic        busy;
    logic [15:0] frame_cnt;

    int n_checks;
    int n_errors;

    python_emulator #(
        .KERNELS    (KERNELS),
        .LINES      (LINES),
        .H_BLANK    (H_BLANK),
        .TRIG_DELAY (TRIG_DELAY)
    ) dut (
        .c         (c),
        .rst       (rst),
        .en        (en),
        .trigger   (trigger),
        .q         (q),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    initial begin
        c = 1'b0;
        forever #5 c = ~c;
    end

    // ------------------------------------------------------------------
    // Reference model: a frame is a list of words pushed on acceptance
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [39:0] q;
        logic        busy;
        logic [15:0] fc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [15:0] m_fc;
    bit          started;

    function automatic logic [7:0] sync_of(input int k, input int l);
        if (k == 0)            return (l == 0) ? 8'hAA : 8'h2A;
        if (k == KERNELS - 1)  return (l == LINES - 1) ? 8'hCA : 8'h4A;
        return 8'h0D;
    endfunction

    task automatic build_frame();
        for (int d = 0; d < TRIG_DELAY; d++)
            exp_q.push_back('{TR_WORD, 1'b1, m_fc});
        for (int l = 0; l < LINES; l++) begin
            for (int k = 0; k < KERNELS; k++) begin
                logic [31:0] dat;
                for (int j = 0; j < 4; j++)
                    dat[8*j +: 8] = 8'((l + 4*k + j + int'(m_fc[7:0])) % 256);
                exp_q.push_back('{{sync_of(k, l), dat}, 1'b1, m_fc});
            end
            if (l < LINES - 1)
                for (int h = 0; h < H_BLANK; h++)
                    exp_q.push_back('{TR_WORD, 1'b1, m_fc});
        end
        m_fc = m_fc + 16'd1;
    endtask

    always @(posedge c) begin
        if (rst) begin
            exp_q.delete();
            m_fc = 16'd0;
            cur  = '{TR_WORD, 1'b0, 16'd0};
        end else begin
            if (!cur.busy && trigger && en)
                build_frame();
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else                  cur = '{TR_WORD, 1'b0, m_fc};
        end
        started = 1'b1;
    end

    // Per-cycle compare against the model
    always @(negedge c) begin
        if (started) begin
            n_checks++;
            if ({q, busy, frame_cnt} !== {cur.q, cur.busy, cur.fc}) begin
                n_errors++;
                $display("FAIL model t=%0t actual q=%h busy=%b fc=%0d required q=%h busy=%b fc=%0d",
                         $time, q, busy, frame_cnt, cur.q, cur.busy, cur.fc);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed literal checks
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    logic [7:0] exp_sync [0:17];

    // Trigger pulse then walk the 18 words after acceptance (TR delay word,
    // 16 frame words incl. blanking, one trailing idle word).
    task automatic frame_seq(input string tag, input logic [31:0] fs_data,
                             input logic [31:0] l1k2_data, input logic [15:0] fc_after,
                             input int stop_at, input bit disturb);
        @(posedge c); #1 trigger = 1'b1;
        @(posedge c); #1 trigger = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(negedge c);
            if (i == stop_at) begin
                rst = 1'b1;
                @(negedge c);
                check({tag, " rst_q"},    64'(q),         64'(TR_WORD));
                check({tag, " rst_busy"}, 64'(busy),      64'd0);
                check({tag, " rst_fc"},   64'(frame_cnt), 64'd0);
                rst = 1'b0;
                return;
            end
            check({tag, " sync"}, 64'(q[39:32]), 64'(exp_sync[i]));
            if (i == 1)  check({tag, " fs_data"},   64'(q[31:0]), 64'(fs_data));
            if (i == 9)  check({tag, " l1k2_data"}, 64'(q[31:0]), 64'(l1k2_data));
            if (i < 17)  check({tag, " busy"}, 64'(busy), 64'd1);
            if (i == 17) begin
                check({tag, " busy_end"}, 64'(busy), 64'd0);
                check({tag, " fc_end"},   64'(frame_cnt), 64'(fc_after));
            end
            if (disturb) begin
                if (i == 3)  trigger = 1'b1;
                if (i == 5)  en = 1'b0;
                if (i == 7)  trigger = 1'b0;
                if (i == 9)  trigger = 1'b1;
                if (i == 11) begin en = 1'b1; trigger = 1'b0; end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        started  = 1'b0;
        m_fc     = 16'd0;
        cur      = '{TR_WORD, 1'b0, 16'd0};
        exp_sync = '{8'hE9, 8'hAA, 8'h0D, 8'h0D, 8'h4A, 8'hE9, 8'hE9,
                     8'h2A, 8'h0D, 8'h0D, 8'h4A, 8'hE9, 8'hE9,
                     8'h2A, 8'h0D, 8'h0D, 8'hCA, 8'hE9};
        rst     = 1'b1;
        en      = 1'b1;
        trigger = 1'b1;

        // Reset held with trigger asserted
        for (int i = 0; i < 3; i++) begin
            @(negedge c);
            check("reset_q",    64'(q),         64'(TR_WORD));
            check("reset_busy", 64'(busy),      64'd0);
            check("reset_fc",   64'(frame_cnt), 64'd0);
        end
        rst     = 1'b0;
        trigger = 1'b0;
        repeat (2) @(negedge c);

        frame_seq("frame1",  32'h03020100, 32'h0C0B0A09, 16'd1, -1, 1'b0);
        frame_seq("frame2",  32'h04030201, 32'h0D0C0B0A, 16'd2, -1, 1'b0);
        frame_seq("disturb", 32'h05040302, 32'h0E0D0C0B, 16'd3, -1, 1'b1);
        repeat (6) @(negedge c);
        check("one_frame_only_busy", 64'(busy),      64'd0);
        check("one_frame_only_fc",   64'(frame_cnt), 64'd3);

        frame_seq("midrst",  32'h06050403, 32'h0F0E0D0C, 16'd4, 8, 1'b0);
        frame_seq("afterrst", 32'h03020100, 32'h0C0B0A09, 16'd1, -1, 1'b0);

        // en low: triggers ignored
        @(posedge c); #1 en = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge c); #1 trigger = ($urandom_range(0, 2) == 0);
        end
        @(negedge c);
        check("en0_busy", 64'(busy), 64'd0);
        check("en0_q",    64'(q),    64'(TR_WORD));
        check("en0_fc",   64'(frame_cnt), 64'd1);
        @(posedge c); #1 trigger = 1'b0; en = 1'b1;

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            @(posedge c);
            #1;
            trigger = ($urandom_range(0, 7) == 0);
            en      = ($urandom_range(0, 9) != 0);
            rst     = ($urandom_range(0, 599) == 0);
        end
        @(posedge c); #1 rst = 1'b0; trigger = 1'b0;
        repeat (3) @(negedge c);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
